btb_assoc: RTL and testbench
============================

// Module: btb_assoc
// PURPOSE
//  Parametrised set-associative branch target buffer with per-entry saturating direction counters.
//  Sits in IF: looked up with fetch PC, returns hit/target/predicted-taken one cycle later.
//  Updated from EX with resolved branches; supports single-entry invalidate and whole-table flush FSM.
//  Storage is flops (no memory macro), so reset clears all valid bits.
// PARAMETERS
//  SETS       64  number of sets, power of 2; IDX_W=$clog2(SETS), TAG_W=31-IDX_W
//  WAYS       2   ways per set, power of 2, 1..8
//  CNT_WIDTH  2   direction-counter width, >=1
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   asynchronous reset, active-low
//  btb_rd         in   1   lookup request
//  pc_r           in   31  lookup PC [31:1]; index=pc[IDX_W:1], tag=pc[31:IDX_W+1]
//  btb_hit        out  1   registered: lookup one cycle ago hit a valid entry
//  target_pc_r    out  31  registered target [31:1] of hit entry
//  pred_taken     out  1   registered counter MSB of hit entry; 0 on miss
//  btb_wr         in   1   resolved-branch update
//  btb_invalid    in   1   qualifies btb_wr: invalidate matching entry instead of update
//  pc_w           in   31  branch PC [31:1]
//  target_pc_w    in   32  resolved target; bit 0 ignored
//  upd_taken      in   1   resolved direction
//  btb_flush      in   1   pulse: invalidate whole table
//  btb_busy       out  1   flush sweep in progress
// BEHAVIOUR
//  Reset: all valid=0, counters=2^(CNT_WIDTH-1)-1, RR pointers=0, FSM=IDLE; btb_hit=0, target_pc_r=0, pred_taken=0, btb_busy=0.
//  Lookup: btb_rd at edge N -> results at N+1. No btb_rd -> btb_hit=0, pred_taken=0 next cycle; target_pc_r holds.
//   Hit = valid & tag match in any way of set; by construction at most one way matches; lowest way wins defensively.
//  Update (btb_wr & !btb_invalid), in IDLE only:
//   hit: overwrite target; counter saturating +1 if upd_taken else -1 (no wrap at 0 / all-ones).
//   miss & upd_taken: allocate lowest invalid way, else way at set RR pointer; RR pointer +1 mod WAYS
//    only when a valid way was evicted; entry valid=1, tag, target, counter=2^(CNT_WIDTH-1) (weak taken).
//   miss & !upd_taken: no change.
//  Invalidate (btb_wr & btb_invalid): matching way valid=0; miss is a no-op.
//  Simultaneous btb_rd and btb_wr, same cycle: lookup reads pre-write state unless BTB_BYPASS_EN (see below).
//  FSM: IDLE -btb_flush-> FLUSH (set counter=0). FLUSH: each cycle clear valid, reset counters and RR of set[cnt];
//   cnt==SETS-1 -> IDLE. Sweep takes SETS cycles; btb_busy=1 throughout, 0 on the cycle back in IDLE.
//   During FLUSH: btb_wr dropped, btb_rd returns btb_hit=0, btb_flush ignored (no restart).
//   btb_flush in IDLE with btb_wr same cycle: flush wins, write dropped.
//  reset_n asserted mid-flush: immediate return to IDLE with full reset state.
// CONFIGURATION
//  BTB_BYPASS_EN defined: btb_rd and a non-dropped btb_wr to the same set+tag in one cycle -> lookup returns the
//   post-write result (update: hit=1, new target, new counter MSB; allocate: hit=1, weak-taken; invalidate: hit=0).
//  Undefined: lookup returns pre-write contents; no forwarding logic built.
// TESTING
//  1 Reset, btb_rd pc_r=0x0000_1000 -> btb_hit=0, pred_taken=0 next cycle.
//  2 btb_wr pc_w=0x1000 target 0x2000 upd_taken=1; then rd 0x1000 -> hit=1, target_pc_r=0x1000 ([31:1]), pred_taken=1.
//  3 Same PC: 2x not-taken updates -> counter 10->01->00, pred_taken=0; 3rd not-taken stays 00; then 2x taken -> 10.
//  4 WAYS=2: allocate 3 taken PCs in one set (A,B,C) -> C evicts A (RR=0), rd A miss, B and C hit; RR=1.
//  5 Fill 5 entries, pulse btb_flush -> btb_busy=1 exactly SETS cycles, btb_wr during sweep dropped, all rd miss after.
//  6 Same-cycle rd+wr allocate PC 0x40: without BTB_BYPASS_EN hit=0, with it hit=1; btb_invalid then rd -> hit=0.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters and a flush sweep.
// Latency: lookup results registered one cycle after btb_rd; updates take effect at the next edge.
// Backpressure: btb_busy high during the SETS-cycle flush sweep; writes dropped and lookups miss meanwhile.
// Optional feature macro: BTB_BYPASS_EN (forward a same-cycle write to a same-entry lookup).
module btb_assoc #(
    parameter int SETS      = 64,
    parameter int WAYS      = 2,
    parameter int CNT_WIDTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btb_rd,
    input  logic [30:0] pc_r,
    output logic        btb_hit,
    output logic [30:0] target_pc_r,
    output logic        pred_taken,
    input  logic        btb_wr,
    input  logic        btb_invalid,
    input  logic [30:0] pc_w,
    input  logic [31:0] target_pc_w,
    input  logic        upd_taken,
    input  logic        btb_flush,
    output logic        btb_busy
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 31 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_WT   = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    logic                 valid_q [SETS][WAYS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [30:0]          tgt_q   [SETS][WAYS];
    logic [CNT_WIDTH-1:0] cnt_q   [SETS][WAYS];
    logic [WAY_W-1:0]     rr_q    [SETS];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] fcnt_q, fcnt_d;
    logic             hit_q, hit_d, pred_q, pred_d;
    logic [30:0]      target_q, target_d;

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_hit, wr_hit, any_inv;
    logic [WAY_W-1:0] rd_way, wr_hit_way, inv_way, wr_way;
    logic             wr_go, do_upd, do_alloc, do_inv, do_evict;
    logic [CNT_WIDTH-1:0] new_cnt;
    logic             unused_tgt_bit0;

    assign rd_idx = pc_r[IDX_W-1:0];
    assign rd_tag = pc_r[30:IDX_W];
    assign wr_idx = pc_w[IDX_W-1:0];
    assign wr_tag = pc_w[30:IDX_W];
    assign unused_tgt_bit0 = target_pc_w[0];

    // Tag match for lookup and write ports; descending scan so the lowest way wins.
    always_comb begin
        rd_hit = 1'b0; rd_way = '0;
        wr_hit = 1'b0; wr_hit_way = '0;
        any_inv = 1'b0; inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
                rd_hit = 1'b1; rd_way = WAY_W'(w);
            end
            if (valid_q[wr_idx][w] && tag_q[wr_idx][w] == wr_tag) begin
                wr_hit = 1'b1; wr_hit_way = WAY_W'(w);
            end
            if (!valid_q[wr_idx][w]) begin
                any_inv = 1'b1; inv_way = WAY_W'(w);
            end
        end
    end

    // Classify the write: a flush request in the same cycle takes precedence over it.
    always_comb begin
        wr_go    = btb_wr && (state_q == IDLE) && !btb_flush;
        do_upd   = wr_go && !btb_invalid && wr_hit;
        do_alloc = wr_go && !btb_invalid && !wr_hit && upd_taken;
        do_inv   = wr_go && btb_invalid && wr_hit;
        do_evict = do_alloc && !any_inv;
        wr_way   = wr_hit ? wr_hit_way : (any_inv ? inv_way : rr_q[wr_idx]);
        new_cnt  = CNT_WT;
        if (do_upd) begin
            new_cnt = cnt_q[wr_idx][wr_way];
            if (upd_taken && new_cnt != CNT_MAX)
                new_cnt = new_cnt + 1'b1;
            else if (!upd_taken && new_cnt != '0)
                new_cnt = new_cnt - 1'b1;
        end
    end

    // Entry storage: reset/flush clears sets, otherwise apply the classified write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    tgt_q[s][w]   <= '0;
                    cnt_q[s][w]   <= CNT_INIT;
                end
            end
        end else if (state_q == FLUSH) begin
            rr_q[fcnt_q] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[fcnt_q][w] <= 1'b0;
                cnt_q[fcnt_q][w]   <= CNT_INIT;
            end
        end else begin
            if (do_upd || do_alloc) begin
                valid_q[wr_idx][wr_way] <= 1'b1;
                tag_q[wr_idx][wr_way]   <= wr_tag;
                tgt_q[wr_idx][wr_way]   <= target_pc_w[31:1];
                cnt_q[wr_idx][wr_way]   <= new_cnt;
            end
            if (do_inv)
                valid_q[wr_idx][wr_way] <= 1'b0;
            if (do_evict)
                rr_q[wr_idx] <= (rr_q[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[wr_idx] + 1'b1;
        end
    end

    // Next lookup result; target holds unless a hit supplies a new one.
    always_comb begin
        hit_d    = 1'b0;
        pred_d   = 1'b0;
        target_d = target_q;
        if (btb_rd && state_q == IDLE && rd_hit) begin
            hit_d    = 1'b1;
            target_d = tgt_q[rd_idx][rd_way];
            pred_d   = cnt_q[rd_idx][rd_way][CNT_WIDTH-1];
        end
`ifdef BTB_BYPASS_EN
        if (btb_rd && rd_idx == wr_idx && rd_tag == wr_tag) begin
            if (do_upd || do_alloc) begin
                hit_d    = 1'b1;
                target_d = target_pc_w[31:1];
                pred_d   = new_cnt[CNT_WIDTH-1];
            end else if (do_inv) begin
                hit_d    = 1'b0;
                target_d = target_q;
                pred_d   = 1'b0;
            end
        end
`endif
    end

    // Flush FSM next state: sweep one set per cycle, then return to IDLE.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: if (btb_flush) begin
                state_d = FLUSH;
                fcnt_d  = '0;
            end
            FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == IDX_W'(SETS - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            hit_q    <= 1'b0;
            pred_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            hit_q    <= hit_d;
            pred_q   <= pred_d;
            target_q <= target_d;
        end
    end

    assign btb_hit     = hit_q;
    assign pred_taken  = pred_q;
    assign target_pc_r = target_q;
    assign btb_busy    = (state_q == FLUSH);

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SETS=64, WAYS=2, CNT_WIDTH=2).
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Same-cycle read/write expectations follow the BTB_BYPASS_EN build option.
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        btb_rd;
    logic [30:0] pc_r;
    logic        btb_hit;
    logic [30:0] target_pc_r;
    logic        pred_taken;
    logic        btb_wr;
    logic        btb_invalid;
    logic [30:0] pc_w;
    logic [31:0] target_pc_w;
    logic        upd_taken;
    logic        btb_flush;
    logic        btb_busy;

    int checks = 0;
    int errors = 0;
    int n;
    logic bypass;

    btb_assoc #(.SETS(64), .WAYS(2), .CNT_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .btb_rd(btb_rd), .pc_r(pc_r),
        .btb_hit(btb_hit), .target_pc_r(target_pc_r), .pred_taken(pred_taken),
        .btb_wr(btb_wr), .btb_invalid(btb_invalid), .pc_w(pc_w),
        .target_pc_w(target_pc_w), .upd_taken(upd_taken),
        .btb_flush(btb_flush), .btb_busy(btb_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [30:0] pc, input logic [31:0] tgt, input logic tk);
        btb_wr = 1'b1; btb_invalid = 1'b0; pc_w = pc; target_pc_w = tgt; upd_taken = tk;
        tick();
        btb_wr = 1'b0;
    endtask

    task automatic inv(input logic [30:0] pc);
        btb_wr = 1'b1; btb_invalid = 1'b1; pc_w = pc;
        tick();
        btb_wr = 1'b0; btb_invalid = 1'b0;
    endtask

    task automatic rd(input logic [30:0] pc);
        btb_rd = 1'b1; pc_r = pc;
        tick();
        btb_rd = 1'b0;
    endtask

    initial begin
`ifdef BTB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        reset_n = 1'b0; btb_rd = 0; pc_r = '0; btb_wr = 0; btb_invalid = 0;
        pc_w = '0; target_pc_w = '0; upd_taken = 0; btb_flush = 0;
        #12;
        chk("rst_hit", btb_hit, 0);
        chk("rst_tgt", target_pc_r, 0);
        chk("rst_pred", pred_taken, 0);
        chk("rst_busy", btb_busy, 0);
        reset_n = 1'b1;
        tick();

        // Cold lookup misses
        rd(31'h1000);
        chk("cold_hit", btb_hit, 0);
        chk("cold_pred", pred_taken, 0);

        // Allocate weak-taken entry
        wr(31'h1000, 32'h2000, 1);
        rd(31'h1000);
        chk("alloc_hit", btb_hit, 1);
        chk("alloc_tgt", target_pc_r, 32'h1000);
        chk("alloc_pred", pred_taken, 1);
        tick();
        chk("nord_hit", btb_hit, 0);
        chk("nord_tgt_hold", target_pc_r, 32'h1000);

        // Counter saturation: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10
        wr(31'h1000, 32'h2000, 0); rd(31'h1000); chk("nt1_pred", pred_taken, 0);
        wr(31'h1000, 32'h2000, 0); rd(31'h1000); chk("nt2_pred", pred_taken, 0);
        wr(31'h1000, 32'h2000, 0); rd(31'h1000); chk("nt3_hit", btb_hit, 1);
        wr(31'h1000, 32'h2000, 1); rd(31'h1000); chk("t1_pred_floor", pred_taken, 0);
        wr(31'h1000, 32'h2000, 1); rd(31'h1000); chk("t2_pred", pred_taken, 1);
        wr(31'h1000, 32'h2000, 1);
        wr(31'h1000, 32'h3000, 1);
        wr(31'h1000, 32'h3000, 0); rd(31'h1000); chk("ceil_pred", pred_taken, 1);
        chk("retarget", target_pc_r, 32'h1800);
        wr(31'h1000, 32'h3000, 0); rd(31'h1000); chk("ceil_pred2", pred_taken, 0);

        // Replacement in set 5
        wr(31'h105, 32'h0A00, 1);
        wr(31'h205, 32'h0B00, 1);
        wr(31'h305, 32'h0C00, 1);
        rd(31'h205); chk("rr_B_hit", btb_hit, 1); chk("rr_B_tgt", target_pc_r, 32'h580);
        rd(31'h105); chk("rr_A_miss", btb_hit, 0); chk("miss_tgt_hold", target_pc_r, 32'h580);
        rd(31'h305); chk("rr_C_hit", btb_hit, 1); chk("rr_C_tgt", target_pc_r, 32'h600);
        wr(31'h405, 32'h0D00, 1);
        rd(31'h205); chk("rr1_B_miss", btb_hit, 0);
        rd(31'h305); chk("rr1_C_hit", btb_hit, 1);
        rd(31'h405); chk("rr1_D_hit", btb_hit, 1);
        wr(31'h505, 32'h0E00, 0);
        rd(31'h505); chk("nt_miss_noalloc", btb_hit, 0);
        rd(31'h305); chk("nt_miss_keepC", btb_hit, 1);

        // Flush sweep
        for (int i = 0; i < 5; i++) wr(31'h10 + 31'(i), 32'h100 + 32'(i * 2), 1);
        btb_flush = 1'b1;
        tick();
        btb_flush = 1'b0;
        chk("flush_busy", btb_busy, 1);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            if (k == 5) begin
                btb_rd = 1; pc_r = 31'h10;
                btb_wr = 1; pc_w = 31'h80; target_pc_w = 32'h900; upd_taken = 1;
            end
            if (k == 10) btb_flush = 1'b1;
            tick();
            if (k == 5) begin
                chk("flush_rd_hit", btb_hit, 0);
                btb_rd = 0; btb_wr = 0;
            end
            btb_flush = 1'b0;
            if (btb_busy) n++;
            else break;
        end
        chk("flush_cycles", n, 64);
        rd(31'h80);  chk("flush_wr_dropped", btb_hit, 0);
        rd(31'h12);  chk("flush_miss_12", btb_hit, 0);
        rd(31'h1000); chk("flush_miss_1000", btb_hit, 0);
        rd(31'h305); chk("flush_miss_305", btb_hit, 0);

        // Same-cycle read + write
        btb_rd = 1; pc_r = 31'h40;
        btb_wr = 1; btb_invalid = 0; pc_w = 31'h40; target_pc_w = 32'h500; upd_taken = 1;
        tick();
        btb_rd = 0; btb_wr = 0;
        chk("byp_alloc_hit", btb_hit, {31'b0, bypass});
        chk("byp_alloc_pred", pred_taken, {31'b0, bypass});
        rd(31'h40);
        chk("after_alloc_hit", btb_hit, 1);
        chk("after_alloc_tgt", target_pc_r, 32'h280);
        btb_rd = 1; pc_r = 31'h40;
        btb_wr = 1; btb_invalid = 1; pc_w = 31'h40;
        tick();
        btb_rd = 0; btb_wr = 0; btb_invalid = 0;
        chk("byp_inv_hit", btb_hit, {31'b0, ~bypass});
        rd(31'h40); chk("inv_hit", btb_hit, 0);
        inv(31'h41);
        rd(31'h41); chk("inv_miss_noop", btb_hit, 0);

        // Reset during flush
        wr(31'h99, 32'h4000, 1);
        rd(31'h99); chk("pre_rst_hit", btb_hit, 1);
        btb_flush = 1'b1; tick(); btb_flush = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", btb_busy, 0);
        chk("midrst_tgt", target_pc_r, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("postrst_busy", btb_busy, 0);
        rd(31'h99); chk("postrst_miss", btb_hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
